// File: rtl/sprite_motion_engine_pkg.sv
// Shared types and constants for the sprite motion engine: per-object state record,
// sweep FSM encoding, default display geometry and the per-object reset-state helper.
// No logic of its own; latency and backpressure are properties of the users.
package sprite_pkg;

    localparam int POS_W           = 10;   // coordinate width
    localparam int COLOR_W         = 3;    // palette index width
    localparam int DISP_W_DEF      = 640;
    localparam int DISP_H_DEF      = 480;
    localparam int SPRITE_SIZE_DEF = 128;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

    typedef struct packed {
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
        logic               dir_x;   // 1 = moving right
        logic               dir_y;   // 1 = moving down
        logic [COLOR_W-1:0] color;
    } obj_state_t;

    // Staggered start so the sprites do not overlap at power-up.
    function automatic obj_state_t obj_reset_state(input int idx, input int ofs_x, input int ofs_y);
        obj_state_t s;
        int         px;
        int         py;
        px      = idx * ofs_x;
        py      = idx * ofs_y;
        s.x     = px[POS_W-1:0];
        s.y     = py[POS_W-1:0];
        s.dir_x = 1'b1;
        s.dir_y = idx[0];
        s.color = idx[COLOR_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Signal bundle between the frame/gamepad side and the sprite motion engine.
// master: drives frame_tick, speed and buttons, observes positions/colours/status.
// slave: the engine; all of its outputs are registered.
interface sprite_motion_engine_if #(
    parameter int NUM_OBJ = 4,
    parameter int POS_W   = sprite_pkg::POS_W,
    parameter int SPEED_W = 3
);
    logic                     frame_tick;
    logic [SPEED_W-1:0]       speed;
    logic                     btn_start;
    logic                     btn_up;
    logic                     btn_down;
    logic                     btn_left;
    logic                     btn_right;
    logic [NUM_OBJ*POS_W-1:0] pos_x;
    logic [NUM_OBJ*POS_W-1:0] pos_y;
    logic [NUM_OBJ*3-1:0]     color_idx;
    logic                     manual_mode;
    logic                     busy;
    logic [NUM_OBJ-1:0]       edge_hit;
    logic                     overrun;

    modport master (
        output frame_tick, speed, btn_start, btn_up, btn_down, btn_left, btn_right,
        input  pos_x, pos_y, color_idx, manual_mode, busy, edge_hit, overrun
    );

    modport slave (
        input  frame_tick, speed, btn_start, btn_up, btn_down, btn_left, btn_right,
        output pos_x, pos_y, color_idx, manual_mode, busy, edge_hit, overrun
    );
endinterface

// File: rtl/sprite_motion_engine_axis.sv
// One-axis position step for a single sprite: auto bounce or gamepad-driven manual move.
// Purely combinational, zero latency.
// No backpressure; the result is consumed by the caller on the same cycle.
// Ports: pos_i/dir_i current axis state, speed_i step, max_i upper clamp,
//        manual_i selects manual mode, dec_i/inc_i button toward 0 / toward max,
//        pos_o/dir_o next axis state, bounce_o edge reached in auto mode.
module sprite_axis_step #(
    parameter int POS_W   = 10,
    parameter int SPEED_W = 3
) (
    input  logic [POS_W-1:0]   pos_i,
    input  logic               dir_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [POS_W-1:0]   max_i,
    input  logic               manual_i,
    input  logic               dec_i,
    input  logic               inc_i,
    output logic [POS_W-1:0]   pos_o,
    output logic               dir_o,
    output logic               bounce_o
);

    logic [POS_W-1:0] spd_n;
    logic [POS_W:0]   sum_w;
    logic [POS_W-1:0] diff_n;
    logic             at_high;
    logic             at_low;
    logic             dir_eff;

    // Sum is one bit wider so pos+speed past the top can never alias to a small value.
    assign spd_n   = {{(POS_W-SPEED_W){1'b0}}, speed_i};
    assign sum_w   = {1'b0, pos_i} + {1'b0, spd_n};
    assign diff_n  = pos_i - spd_n;
    assign at_high = (sum_w >= {1'b0, max_i});
    assign at_low  = (pos_i <= spd_n);

    // Button overrides in auto mode act before the edge test; left/up has priority.
    assign dir_eff = dec_i ? 1'b0 : (inc_i ? 1'b1 : dir_i);

    always_comb begin
        pos_o    = pos_i;
        dir_o    = dir_i;
        bounce_o = 1'b0;
        if (speed_i != '0) begin
            if (manual_i) begin
                // Opposing buttons cancel; direction is kept for the return to auto.
                if (dec_i && !inc_i) begin
                    pos_o = at_low ? '0 : diff_n;
                end else if (inc_i && !dec_i) begin
                    pos_o = at_high ? max_i : sum_w[POS_W-1:0];
                end
            end else begin
                dir_o = dir_eff;
                if (dir_eff) begin
                    if (at_high) begin
                        pos_o    = max_i;
                        dir_o    = 1'b0;
                        bounce_o = 1'b1;
                    end else begin
                        pos_o = sum_w[POS_W-1:0];
                    end
                end else begin
                    if (at_low) begin
                        pos_o    = '0;
                        dir_o    = 1'b1;
                        bounce_o = 1'b1;
                    end else begin
                        pos_o = diff_n;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame motion controller for NUM_OBJ bouncing sprites, one shared update unit, one object per clock.
// Latency: sweep starts the cycle after frame_tick and takes exactly NUM_OBJ cycles (busy high throughout).
// No backpressure: a frame_tick arriving mid-sweep is dropped and flagged on overrun.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries tick/speed/buttons in,
//        packed positions, colours and status pulses out.
module sprite_motion_engine
    import sprite_pkg::*;
#(
    parameter int NUM_OBJ     = 4,
    parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
    parameter int DISP_W      = DISP_W_DEF,
    parameter int DISP_H      = DISP_H_DEF,
    parameter int SPEED_W     = 3,
    parameter int OFS_X       = 64,
    parameter int OFS_Y       = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sprite_motion_engine_if.slave   bus
);

    localparam int               IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    localparam logic [POS_W-1:0] MAX_X    = POS_W'(DISP_W - SPRITE_SIZE);
    localparam logic [POS_W-1:0] MAX_Y    = POS_W'(DISP_H - SPRITE_SIZE);

    sweep_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    obj_state_t         obj_q [NUM_OBJ];
    logic               manual_q, manual_d;
    logic               start_prev_q, start_prev_d;
    logic [NUM_OBJ-1:0] edge_q, edge_d;
    logic               overrun_q, overrun_d;

    obj_state_t         cur;
    obj_state_t         obj_upd;
    logic               obj0_sel;
    logic               man_sel;
    logic [POS_W-1:0]   nx, ny;
    logic               ndx, ndy;
    logic               bx, by;

    // ---------------- shared update unit ----------------
    assign cur      = obj_q[idx_q];
    assign obj0_sel = (idx_q == '0);
    assign man_sel  = manual_q & obj0_sel;

    sprite_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_x (
        .pos_i    (cur.x),
        .dir_i    (cur.dir_x),
        .speed_i  (bus.speed),
        .max_i    (MAX_X),
        .manual_i (man_sel),
        .dec_i    (obj0_sel & bus.btn_left),
        .inc_i    (obj0_sel & bus.btn_right),
        .pos_o    (nx),
        .dir_o    (ndx),
        .bounce_o (bx)
    );

    sprite_axis_step #(.POS_W(POS_W), .SPEED_W(SPEED_W)) u_step_y (
        .pos_i    (cur.y),
        .dir_i    (cur.dir_y),
        .speed_i  (bus.speed),
        .max_i    (MAX_Y),
        .manual_i (man_sel),
        .dec_i    (obj0_sel & bus.btn_up),
        .inc_i    (obj0_sel & bus.btn_down),
        .pos_o    (ny),
        .dir_o    (ndy),
        .bounce_o (by)
    );

    // A corner hit bounces both axes but advances the colour only once.
    always_comb begin
        obj_upd       = cur;
        obj_upd.x     = nx;
        obj_upd.y     = ny;
        obj_upd.dir_x = ndx;
        obj_upd.dir_y = ndy;
        obj_upd.color = cur.color + COLOR_W'(bx | by);
    end

    // ---------------- sweep FSM ----------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        manual_d     = manual_q;
        start_prev_d = start_prev_q;
        edge_d       = '0;
        overrun_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    state_d      = ST_SWEEP;
                    idx_d        = '0;
                    // Start is only sampled at frame rate, which debounces it for free.
                    start_prev_d = bus.btn_start;
                    if (bus.btn_start && !start_prev_q) begin
                        manual_d = ~manual_q;
                    end
                end
            end
            ST_SWEEP: begin
                edge_d[idx_q] = bx | by;
                overrun_d     = bus.frame_tick;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            manual_q     <= 1'b0;
            start_prev_q <= 1'b0;
            edge_q       <= '0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                obj_q[i] <= obj_reset_state(i, OFS_X, OFS_Y);
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            manual_q     <= manual_d;
            start_prev_q <= start_prev_d;
            edge_q       <= edge_d;
            overrun_q    <= overrun_d;
            // Only the object under the sweep pointer moves, so each object's
            // outputs stay frame-consistent outside its own update cycle.
            if (state_q == ST_SWEEP) begin
                obj_q[idx_q] <= obj_upd;
            end
        end
    end

    // ---------------- outputs (all from registers) ----------------
    always_comb begin
        bus.pos_x     = '0;
        bus.pos_y     = '0;
        bus.color_idx = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            bus.pos_x[i*POS_W +: POS_W]       = obj_q[i].x;
            bus.pos_y[i*POS_W +: POS_W]       = obj_q[i].y;
            bus.color_idx[i*COLOR_W +: COLOR_W] = obj_q[i].color;
        end
    end

    assign bus.manual_mode = manual_q;
    assign bus.busy        = (state_q == ST_SWEEP);
    assign bus.edge_hit    = edge_q;
    assign bus.overrun     = overrun_q;

endmodule
